m_hex_scan: RTL and testbench
=============================

# m_hex_scan

Time-multiplexed driver for the four-digit seven-segment display of the watch. It takes the four 4-bit digit codes produced by the watch datapath and shares one segment bus among the four digits in round-robin slots. A blanking gap at the start of each slot prevents ghosting. A per-digit blink mask flashes the digit being edited in setting mode. It sits between the watch core (`Hex_0`..`Hex_3`) and the board pins.

## Interface
Parameters:
- `IN_CLK_HZ`, default 50_000_000: input clock frequency.
- `SCAN_HZ`, default 1000: slot rate. Slot length is P = IN_CLK_HZ/SCAN_HZ cycles.
- `BLANK_CYC`, default 4: cycles at slot start with all anodes off. Elaboration `$error` if P ≤ BLANK_CYC.
- `BLINK_HZ`, default 2: blink rate. The blink phase toggles every B = IN_CLK_HZ/(2·BLINK_HZ) cycles. Elaboration `$error` if B < 1.

Ports:
- `clk`  in  1  the single clock. All logic is on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `Hex_0`..`Hex_3`  in  4 each  digit codes. `Hex_0` is the rightmost digit.
- `blink_en`  in  4  bit d set = digit d blinks.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an_n`  out  4  digit anodes, active-low, one-hot-low or all high.
- `frame_tick`  out  1  one-cycle pulse in the first cycle of each digit-0 slot.

## Operation
- State: digit index `d` (0..3), slot counter `sc` (0..P−1), blink counter `bc` (0..B−1), blink phase `ph`, latched code `cur`, latched visibility `vis`.
- `sc` increments every cycle. At `sc`=P−1 it wraps to 0 and `d` advances 0→1→2→3→0.
- `bc` increments every cycle. At B−1 it wraps and `ph` toggles. `ph`=1 means visible.
- Slot phases:
  - BLANK: `sc` < BLANK_CYC.
  - DRIVE: `sc` ≥ BLANK_CYC.
- At `sc`=0, latch `cur` ← `Hex_d` and `vis` ← ¬`blink_en[d]` | `ph`.
  - Input or mask changes mid-slot take effect at the next slot only.
- Decode rules:
  - 0–9 decode to standard digit glyphs.
  - 10–15 decode to A,b,C,d,E,F. This covers transient out-of-range values in setting mode.
- In BLANK, or in DRIVE with `vis`=0: `an_n`=4'b1111 and `seg_n`=7'h7F.
- In DRIVE with `vis`=1: `an_n[d]`=0, other anode bits 1, and `seg_n`=decode(`cur`).
- All outputs are registered, so no combinational path from inputs to outputs.
- Reset values:
  - `an_n`=4'b1111, `seg_n`=7'h7F, `frame_tick`=0.
  - `d`=0, `sc`=0, `bc`=0, `ph`=1.

## Timing
- Slot 0 begins at the first rising edge after `rst` deasserts.
- The first output cycle of a slot shows BLANK values. Outputs lag state by exactly one cycle.
- Per slot: `an_n` all high for BLANK_CYC cycles, then the digit is low for P−BLANK_CYC consecutive cycles.
- Full frame = 4·P cycles. Each anode is active at most P−BLANK_CYC cycles per frame.
- `frame_tick` is high for exactly one cycle per frame, coincident with the first BLANK output cycle of digit 0.
- Blink phase flips mid-slot: no effect until the next slot latch. A digit never partially blinks within a slot.
- `blink_en` all zero: every digit is always driven.
- `blink_en` all ones: the display is fully dark during `ph`=0 slots.
- `rst` asserted mid-slot: outputs go to reset values immediately (asynchronous) and the scan restarts at digit 0.
- Two anodes are never low in the same cycle, including across slot boundaries and reset.

## Configuration
- `HEX_SCAN_DP_EN` defined: adds output `dp_n` (1 bit, active-low, reset 1).
  - `dp_n` = 0 only during DRIVE cycles of digit 2 (hours-minutes separator) while the colon phase is 1.
  - The colon phase toggles every IN_CLK_HZ/2 cycles, giving a 1 Hz flash, and resets to 1.
  - `dp_n` ignores `blink_en`.
- `HEX_SCAN_DP_EN` undefined: the `dp_n` port and the colon counter do not exist. Behaviour is otherwise identical.

## Test plan
Benches use IN_CLK_HZ=400, SCAN_HZ=50 (P=8), BLANK_CYC=2, BLINK_HZ=2 (B=100).
- Hex_0..3 = 1,2,3,4, blink_en=0 → `an_n` sequence per slot: 2 cycles 1111, then 6 cycles 1110 with seg_n=7'b1111001. Then digits 1–3 (1101/1011/0111) with glyphs 2,3,4. `frame_tick` pulse every 32 cycles.
- Hex_1=12 → digit 1 shows glyph "C" (seg_n=7'b1000110).
- blink_en=4'b0010 → digit 1 dark in every slot that starts within cycles 100–199 (mod 200), driven otherwise. No partially lit slot.
- Hex_2 changes 5→6 at `sc`=4 of digit-2 slot → remainder of that slot shows 5. The next digit-2 slot shows 6.
- `rst` pulsed at `sc`=5 of digit 3 → `an_n`=1111 in the same cycle. After release, the first driven anode is digit 0 at cycle 3.
- With `HEX_SCAN_DP_EN` → `dp_n` low only in digit-2 DRIVE cycles of the first 200 cycles, high for the next 200 cycles. Assert one-hot-low `an_n` throughout.

Source files
------------

// File: rtl/m_hex_scan.sv
// Four-digit seven-segment scan driver: round-robin slots with a leading blank gap and per-digit blink.
// Optional HEX_SCAN_DP_EN adds a 1 Hz colon/decimal-point output dp_n on digit 2.
module m_hex_scan #(
  parameter int IN_CLK_HZ = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 4,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Hex_0,
  input  logic [3:0] Hex_1,
  input  logic [3:0] Hex_2,
  input  logic [3:0] Hex_3,
  input  logic [3:0] blink_en,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
`ifdef HEX_SCAN_DP_EN
  output logic       dp_n,
`endif
  output logic       frame_tick
);

  localparam int P   = IN_CLK_HZ / SCAN_HZ;
  localparam int B   = IN_CLK_HZ / (2 * BLINK_HZ);
  localparam int SCW = (P > 1) ? $clog2(P) : 1;
  localparam int BCW = (B > 1) ? $clog2(B) : 1;
  localparam logic [SCW-1:0] SC_LAST  = SCW'(P - 1);
  localparam logic [SCW-1:0] SC_DRIVE = SCW'(BLANK_CYC);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(B - 1);

  if (P <= BLANK_CYC) begin : g_bad_blank
    $error("m_hex_scan: slot length must exceed BLANK_CYC");
  end
  if (B < 1) begin : g_bad_blink
    $error("m_hex_scan: blink half-period must be at least one cycle");
  end

  logic [1:0]     d;
  logic [SCW-1:0] sc;
  logic [BCW-1:0] bc;
  logic           ph;
  logic [3:0]     cur;
  logic           vis;

  logic       slot_start, drive;
  logic [3:0] hex_sel, cur_eff;
  logic       vis_now, vis_eff;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    hex_sel = Hex_0;
    case (d)
      2'd1:    hex_sel = Hex_1;
      2'd2:    hex_sel = Hex_2;
      2'd3:    hex_sel = Hex_3;
      default: hex_sel = Hex_0;
    endcase
    slot_start = (sc == '0);
    drive      = (sc >= SC_DRIVE);
    vis_now    = ~blink_en[d] | ph;
    // On the latch cycle the registers still hold the previous slot, so bypass them.
    cur_eff    = slot_start ? hex_sel : cur;
    vis_eff    = slot_start ? vis_now : vis;
    an_nxt     = 4'hF;
    seg_nxt    = 7'h7F;
    if (drive && vis_eff) begin
      an_nxt  = ~(4'b0001 << d);
      seg_nxt = seg_decode(cur_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d          <= '0;
      sc         <= '0;
      bc         <= '0;
      ph         <= 1'b1;
      cur        <= '0;
      vis        <= 1'b0;
      seg_n      <= 7'h7F;
      an_n       <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      if (sc == SC_LAST) begin
        sc <= '0;
        d  <= d + 2'd1;
      end else begin
        sc <= sc + SCW'(1);
      end
      if (bc == BC_LAST) begin
        bc <= '0;
        ph <= ~ph;
      end else begin
        bc <= bc + BCW'(1);
      end
      if (slot_start) begin
        cur <= hex_sel;
        vis <= vis_now;
      end
      seg_n      <= seg_nxt;
      an_n       <= an_nxt;
      frame_tick <= slot_start && (d == 2'd0);
    end
  end

`ifdef HEX_SCAN_DP_EN
  localparam int CC  = IN_CLK_HZ / 2;
  localparam int CCW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CCW-1:0] CC_LAST = CCW'(CC - 1);

  logic [CCW-1:0] cc;
  logic           colon_ph;

  // Separator follows the digit-2 drive window but is independent of blinking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc       <= '0;
      colon_ph <= 1'b1;
      dp_n     <= 1'b1;
    end else begin
      if (cc == CC_LAST) begin
        cc       <= '0;
        colon_ph <= ~colon_ph;
      end else begin
        cc <= cc + CCW'(1);
      end
      dp_n <= ~(drive && (d == 2'd2) && colon_ph);
    end
  end
`endif

endmodule

// File: tb/tb_m_hex_scan.sv
// Bench for m_hex_scan at P=8, BLANK_CYC=2, B=100: vector table, mid-slot latch and mid-slot reset sequences.
module tb_m_hex_scan;

  localparam int P  = 8;
  localparam int BL = 2;
  localparam int B  = 100;
`ifdef HEX_SCAN_DP_EN
  localparam int W = 13;
`else
  localparam int W = 12;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hex_v [4];
  logic [3:0] blink_v;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_tick;
  logic       dp_w;

  always #5 clk = ~clk;

  m_hex_scan #(.IN_CLK_HZ(400), .SCAN_HZ(50), .BLANK_CYC(BL), .BLINK_HZ(2)) dut (
    .clk(clk), .rst(rst),
    .Hex_0(hex_v[0]), .Hex_1(hex_v[1]), .Hex_2(hex_v[2]), .Hex_3(hex_v[3]),
    .blink_en(blink_v), .seg_n(seg_n), .an_n(an_n),
`ifdef HEX_SCAN_DP_EN
    .dp_n(dp_w),
`endif
    .frame_tick(frame_tick)
  );
`ifndef HEX_SCAN_DP_EN
  assign dp_w = 1'b1;
`endif

  typedef struct packed {
    logic [3:0][3:0] hex;
    logic [3:0]      blink;
    logic [7:0]      frames;
    logic [3:0][6:0] glyph;
  } vec_t;

  vec_t       vecs [4];
  logic [6:0] glyph_tab [16];
  logic [W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int t     = 0;
  logic       use_rec = 1'b0;
  logic [3:0][6:0] rec_glyph;
  logic       lat_vis = 1'b0;
  logic [6:0] lat_glyph = 7'h7F;

  function automatic logic [W-1:0] pack_out();
`ifdef HEX_SCAN_DP_EN
    return {frame_tick, an_n, seg_n, dp_w};
`else
    return {frame_tick, an_n, seg_n};
`endif
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
    end
  endtask

  task automatic check_onehot();
    int zeros = 0;
    for (int i = 0; i < 4; i++) if (an_n[i] == 1'b0) zeros++;
    total++;
    if (zeros > 1) begin
      bad++;
      $display("FAIL onehot t=%0d got an_n=%b exp at most one low", t, an_n);
    end
  endtask

  // One clock: predict the output for state time t, clock it, compare.
  task automatic step();
    int sc, d;
    logic drive, colon;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic ft_e, dp_e;
    logic [W-1:0] e;
    sc = t % P;
    d  = (t / P) % 4;
    if (sc == 0) begin
      lat_vis   = !blink_v[d] || (((t / B) % 2) == 0);
      lat_glyph = use_rec ? rec_glyph[d] : glyph_tab[hex_v[d]];
    end
    drive = (sc >= BL);
    an_e  = 4'hF;
    seg_e = 7'h7F;
    if (drive && lat_vis) begin
      an_e  = ~(4'b0001 << d);
      seg_e = lat_glyph;
    end
    ft_e  = (sc == 0) && (d == 0);
    colon = ((t / 200) % 2) == 0;
    dp_e  = !(drive && (d == 2) && colon);
`ifdef HEX_SCAN_DP_EN
    e = {ft_e, an_e, seg_e, dp_e};
`else
    e = {ft_e, an_e, seg_e};
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("scan", pack_out(), exp_q.pop_front());
    check_onehot();
    t++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [W-1:0] rst_exp;
    int first_drive;
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;

    vecs[0] = '{hex: {4'd4, 4'd3, 4'd2, 4'd1}, blink: 4'b0000, frames: 8'd2,
                glyph: {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
    vecs[1] = '{hex: {4'd4, 4'd3, 4'd12, 4'd1}, blink: 4'b0000, frames: 8'd1,
                glyph: {7'b0011001, 7'b0110000, 7'b1000110, 7'b1111001}};
    vecs[2] = '{hex: {4'd15, 4'd9, 4'd8, 4'd0}, blink: 4'b0010, frames: 8'd8,
                glyph: {7'b0001110, 7'b0010000, 7'b0000000, 7'b1000000}};
    vecs[3] = '{hex: {4'd14, 4'd7, 4'd6, 4'd5}, blink: 4'b1111, frames: 8'd8,
                glyph: {7'b0000110, 7'b1111000, 7'b0000010, 7'b0010010}};

`ifdef HEX_SCAN_DP_EN
    rst_exp = {1'b0, 4'hF, 7'h7F, 1'b1};
`else
    rst_exp = {1'b0, 4'hF, 7'h7F};
`endif

    for (int i = 0; i < 4; i++) hex_v[i] = 4'd0;
    blink_v = 4'b0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", pack_out(), rst_exp);
    rst = 1'b0;
    t = 0;

    use_rec = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) hex_v[i] = vecs[v].hex[i];
      blink_v   = vecs[v].blink;
      rec_glyph = vecs[v].glyph;
      run_steps(int'(vecs[v].frames) * 4 * P);
    end

    // Hex_2 changes at sc=4 of a digit-2 slot; the slot keeps the old code.
    use_rec = 1'b0;
    blink_v = 4'b0000;
    hex_v[0] = 4'd1; hex_v[1] = 4'd2; hex_v[2] = 4'd5; hex_v[3] = 4'd4;
    run_steps(2 * P);
    run_steps(4);
    hex_v[2] = 4'd6;
    run_steps(2);
    check("mid_old", {5'd0, seg_n}, {5'd0, 7'b0010010});
    run_steps(2 + 3 * P + 3);
    check("mid_new", {5'd0, seg_n}, {5'd0, 7'b0000010});
    run_steps(5);

    // Reset at sc=5 of digit 3: outputs clear without waiting for a clock.
    run_steps(5);
    rst = 1'b1;
    #1;
    check("rst_async", pack_out(), rst_exp);
    check_onehot();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_hold", pack_out(), rst_exp);
    rst = 1'b0;
    t = 0;
    first_drive = 0;
    for (int i = 1; i <= 2 * 4 * P; i++) begin
      step();
      if (first_drive == 0 && an_n != 4'hF) first_drive = i;
    end
    check("first_drive", W'(first_drive), W'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
